// File: rtl/hdmi_reg_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_reg_pkg
// Shared types and constants for the HDMI render-core register slave.
//   reg_word_t        : one 32-bit parameter register
//   RESP_OKAY/SLVERR  : AXI response codes used on B and R
//   DEFAULT_NUM_REGS  : default depth of the parameter bank
//   strb_merge()      : bytewise merge of new data into an old word under wstrb
// -----------------------------------------------------------------------------
package hdmi_reg_pkg;

    typedef logic [31:0] reg_word_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int DEFAULT_NUM_REGS = 40;

    // Byte k of the result comes from new_word when strb[k] is set,
    // otherwise it keeps old_word.
    function automatic reg_word_t strb_merge(input reg_word_t  old_word,
                                             input reg_word_t  new_word,
                                             input logic [3:0] strb);
        reg_word_t merged;
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) merged[8*k +: 8] = new_word[8*k +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/hdmi_reg_axi_slave_if.sv
// -----------------------------------------------------------------------------
// hdmi_reg_axi_slave_if
// AXI4-Lite bus bundle between a register master (MicroBlaze or bench) and
// the HDMI register slave. Channels: AW, W, B, AR, R.
//   master modport : drives addresses, write data, valids and readys for B/R
//   slave  modport : drives readys for AW/W/AR, and the B/R payloads
// -----------------------------------------------------------------------------
interface hdmi_reg_axi_slave_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   axi_awaddr;
    logic [2:0]              axi_awprot;
    logic                    axi_awvalid;
    logic                    axi_awready;
    logic [DATA_WIDTH-1:0]   axi_wdata;
    logic [DATA_WIDTH/8-1:0] axi_wstrb;
    logic                    axi_wvalid;
    logic                    axi_wready;
    logic [1:0]              axi_bresp;
    logic                    axi_bvalid;
    logic                    axi_bready;
    logic [ADDR_WIDTH-1:0]   axi_araddr;
    logic [2:0]              axi_arprot;
    logic                    axi_arvalid;
    logic                    axi_arready;
    logic [DATA_WIDTH-1:0]   axi_rdata;
    logic [1:0]              axi_rresp;
    logic                    axi_rvalid;
    logic                    axi_rready;

    modport master (
        output axi_awaddr, axi_awprot, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
               axi_bready, axi_araddr, axi_arprot, axi_arvalid, axi_rready,
        input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
               axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );

    modport slave (
        input  axi_awaddr, axi_awprot, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
               axi_bready, axi_araddr, axi_arprot, axi_arvalid, axi_rready,
        output axi_awready, axi_wready, axi_bresp, axi_bvalid,
               axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );
endinterface

// File: rtl/hdmi_reg_axi_slave_bank.sv
// -----------------------------------------------------------------------------
// hdmi_reg_bank
// Shadow/active parameter storage for the HDMI render core.
//   axi_aclk, axi_reset : clock, synchronous active-high reset
//   wr_en/idx/data/strb : pre-validated shadow write (strobe-merged)
//   rd_idx / rd_data    : combinational shadow read (caller range-checks)
//   commit              : frame-start pulse, copies shadow -> active
//   reg_active          : frame-stable bank for the draw logic
//   dirty               : shadow written since the last commit
// -----------------------------------------------------------------------------
module hdmi_reg_bank
    import hdmi_reg_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             axi_aclk,
    input  logic             axi_reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  reg_word_t        wr_data,
    input  logic [3:0]       wr_strb,
    input  logic [IDX_W-1:0] rd_idx,
    output reg_word_t        rd_data,
    input  logic             commit,
    output reg_word_t        reg_active [NUM_REGS],
    output logic             dirty
);
    reg_word_t shadow [NUM_REGS];
    reg_word_t active [NUM_REGS];

    assign rd_data    = shadow[rd_idx];
    assign reg_active = active;

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            // NOTE: both banks are flops, not RAM, and are cleared so the draw
            // logic starts every session from a known all-zero parameter set.
            shadow <= '{default: '0};
            active <= '{default: '0};
            dirty  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make the commit copy see shadow as
            // it stood before this edge, so a same-cycle write waits a frame.
            if (commit) active <= shadow;
            if (wr_en)  shadow[wr_idx] <= strb_merge(shadow[wr_idx], wr_data, wr_strb);
            if (wr_en)       dirty <= 1'b1;
            else if (commit) dirty <= 1'b0;
        end
    end
endmodule

// File: rtl/hdmi_reg_axi_slave.sv
// -----------------------------------------------------------------------------
// hdmi_reg_axi_slave
// AXI4-Lite register front end for the HDMI render core.
//   axi_aclk, axi_reset : clock, synchronous active-high reset
//   s_axi               : AXI4-Lite slave bus (AW, W, B, AR, R)
//   commit              : frame-start pulse from the VGA stage
//   reg_active          : frame-stable register bank for the draw logic
//   dirty               : shadow differs (was written) since last commit
// AW and W are captured independently into one-entry holds; the write
// executes the edge after both are held. Reads return the shadow bank.
// -----------------------------------------------------------------------------
module hdmi_reg_axi_slave
    import hdmi_reg_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 16,
    parameter int NUM_REGS         = DEFAULT_NUM_REGS
) (
    input  logic                 axi_aclk,
    input  logic                 axi_reset,
    hdmi_reg_axi_slave_if.slave  s_axi,
    input  logic                 commit,
    output reg_word_t            reg_active [NUM_REGS],
    output logic                 dirty
);
    localparam int WIDX_W = C_AXI_ADDR_WIDTH - 2;
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
    localparam logic [WIDX_W-1:0] NUM_REGS_W = WIDX_W'(NUM_REGS);

    // Channel holds and response registers
    logic                        aw_held, w_held;
    logic [WIDX_W-1:0]           aw_widx_q;
    logic [C_AXI_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]           w_strb_q;
    logic                        bvalid_q, rvalid_q;
    logic [1:0]                  bresp_q, rresp_q;
    logic [C_AXI_DATA_WIDTH-1:0] rdata_q;

    logic              wr_exec, wr_in_range, rd_in_range;
    logic [WIDX_W-1:0] ar_widx;
    reg_word_t         rd_data;
    logic              aw_hs, w_hs, ar_hs;

    // Byte-lane address bits and protection fields carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axi.axi_awaddr[1:0], s_axi.axi_araddr[1:0],
                           s_axi.axi_awprot, s_axi.axi_arprot};

    assign s_axi.axi_awready = !axi_reset && !aw_held && !bvalid_q;
    assign s_axi.axi_wready  = !axi_reset && !w_held  && !bvalid_q;
    assign s_axi.axi_arready = !axi_reset && !rvalid_q;
    assign s_axi.axi_bvalid  = bvalid_q;
    assign s_axi.axi_bresp   = bresp_q;
    assign s_axi.axi_rvalid  = rvalid_q;
    assign s_axi.axi_rresp   = rresp_q;
    assign s_axi.axi_rdata   = rdata_q;

    assign aw_hs = s_axi.axi_awvalid && s_axi.axi_awready;
    assign w_hs  = s_axi.axi_wvalid  && s_axi.axi_wready;
    assign ar_hs = s_axi.axi_arvalid && s_axi.axi_arready;

    assign wr_exec     = aw_held && w_held;
    assign wr_in_range = aw_widx_q < NUM_REGS_W;
    assign ar_widx     = s_axi.axi_araddr[C_AXI_ADDR_WIDTH-1:2];
    assign rd_in_range = ar_widx < NUM_REGS_W;

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            aw_held   <= 1'b0;
            aw_widx_q <= '0;
            w_held    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            // Holds can only fill while the other side of the write is pending,
            // never on the edge the write executes (ready is low once held).
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_widx_q <= s_axi.axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= s_axi.axi_wdata;
                w_strb_q <= s_axi.axi_wstrb;
            end

            if (wr_exec) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_q && s_axi.axi_bready) begin
                bvalid_q <= 1'b0;
            end

            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_in_range ? rd_data : '0;
                rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (rvalid_q && s_axi.axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Out-of-range and all-zero-strobe writes never reach the bank, so they
    // neither change a register nor mark the shadow dirty.
    hdmi_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .axi_aclk   (axi_aclk),
        .axi_reset  (axi_reset),
        .wr_en      (wr_exec && wr_in_range && (|w_strb_q)),
        .wr_idx     (aw_widx_q[IDX_W-1:0]),
        .wr_data    (w_data_q),
        .wr_strb    (w_strb_q),
        .rd_idx     (ar_widx[IDX_W-1:0]),
        .rd_data    (rd_data),
        .commit     (commit),
        .reg_active (reg_active),
        .dirty      (dirty)
    );
endmodule

// File: tb/tb_hdmi_reg_axi_slave.sv
// -----------------------------------------------------------------------------
// tb_hdmi_reg_axi_slave
// Self-checking bench for hdmi_reg_axi_slave. Expected B and R responses are
// queued as each transaction is issued and compared by a monitor when the
// matching handshake appears on the bus.
// -----------------------------------------------------------------------------
module tb_hdmi_reg_axi_slave;
    import hdmi_reg_pkg::*;

    localparam int NREGS = 40;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    logic      clk = 1'b0;
    logic      reset;
    logic      commit;
    reg_word_t reg_active [NREGS];
    logic      dirty;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] exp_b [$];
    rd_exp_t    exp_r [$];

    hdmi_reg_axi_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    hdmi_reg_axi_slave #(
        .C_AXI_DATA_WIDTH (32),
        .C_AXI_ADDR_WIDTH (16),
        .NUM_REGS         (NREGS)
    ) dut (
        .axi_aclk   (clk),
        .axi_reset  (reset),
        .s_axi      (bus),
        .commit     (commit),
        .reg_active (reg_active),
        .dirty      (dirty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard side: compare payloads at the handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.axi_bvalid && bus.axi_bready) begin
            if (exp_b.size() == 0) check("b_unexpected", 32'd1, 32'd0);
            else check("bresp", 32'(bus.axi_bresp), 32'(exp_b.pop_front()));
        end
        if (bus.axi_rvalid && bus.axi_rready) begin
            if (exp_r.size() == 0) check("r_unexpected", 32'd1, 32'd0);
            else begin
                rd_exp_t e;
                e = exp_r.pop_front();
                check("rdata", bus.axi_rdata, e.data);
                check("rresp", 32'(bus.axi_rresp), 32'(e.resp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    // Issue one write; AW/W valids rise aw_dly/w_dly cycles after start.
    // Checks bvalid appears exactly one edge after the later handshake.
    task automatic do_write(input logic [15:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input logic [1:0] resp, input logic commit_on_exec);
        logic aw_done, w_done, aw_hs, w_hs;
        int   cyc;
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc     = 0;
        exp_b.push_back(resp);
        while (!(aw_done && w_done) && cyc < 50) begin
            if (!aw_done && cyc >= aw_dly) begin
                bus.axi_awvalid = 1'b1;
                bus.axi_awaddr  = addr;
            end
            if (!w_done && cyc >= w_dly) begin
                bus.axi_wvalid = 1'b1;
                bus.axi_wdata  = data;
                bus.axi_wstrb  = strb;
            end
            @(negedge clk);
            aw_hs = bus.axi_awvalid && bus.axi_awready;
            w_hs  = bus.axi_wvalid  && bus.axi_wready;
            tick();
            if (aw_hs) begin aw_done = 1'b1; bus.axi_awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1'b1; bus.axi_wvalid  = 1'b0; end
            cyc++;
        end
        if (cyc >= 50) check("write_timeout", 32'd1, 32'd0);
        check("bvalid_before_exec", 32'(bus.axi_bvalid), 32'd0);
        if (commit_on_exec) commit = 1'b1;
        tick();
        commit = 1'b0;
        check("bvalid_latency", 32'(bus.axi_bvalid), 32'd1);
        tick();
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [31:0] data,
                           input logic [1:0] resp);
        logic hs;
        int   cyc;
        rd_exp_t e;
        e.data = data;
        e.resp = resp;
        exp_r.push_back(e);
        hs  = 1'b0;
        cyc = 0;
        bus.axi_arvalid = 1'b1;
        bus.axi_araddr  = addr;
        while (!hs && cyc < 50) begin
            @(negedge clk);
            hs = bus.axi_arvalid && bus.axi_arready;
            tick();
            cyc++;
        end
        bus.axi_arvalid = 1'b0;
        if (!hs) check("read_timeout", 32'd1, 32'd0);
        check("rvalid_latency", 32'(bus.axi_rvalid), 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        commit = 1'b0;
        bus.axi_awaddr = '0; bus.axi_awprot = '0; bus.axi_awvalid = 1'b0;
        bus.axi_wdata = '0;  bus.axi_wstrb = '0;  bus.axi_wvalid = 1'b0;
        bus.axi_bready = 1'b1;
        bus.axi_araddr = '0; bus.axi_arprot = '0; bus.axi_arvalid = 1'b0;
        bus.axi_rready = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_awready", 32'(bus.axi_awready), 32'd0);
        check("rst_bvalid",  32'(bus.axi_bvalid),  32'd0);
        check("rst_rvalid",  32'(bus.axi_rvalid),  32'd0);
        check("rst_rdata",   bus.axi_rdata,        32'd0);
        check("rst_dirty",   32'(dirty),           32'd0);
        check("rst_active2", reg_active[2],        32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_awready", 32'(bus.axi_awready), 32'd1);
        check("post_rst_wready",  32'(bus.axi_wready),  32'd1);
        check("post_rst_arready", 32'(bus.axi_arready), 32'd1);
        tick();

        // Full-word write, shadow visible at once, active only after commit
        do_write(16'h0008, 32'h00FF_0000, 4'hF, 0, 0, RESP_OKAY, 1'b0);
        do_read(16'h0008, 32'h00FF_0000, RESP_OKAY);
        check("active2_precommit", reg_active[2], 32'd0);
        check("dirty_after_write", 32'(dirty), 32'd1);
        repeat (2) tick();
        check("active2_stable", reg_active[2], 32'd0);
        pulse_commit();
        check("active2_commit", reg_active[2], 32'h00FF_0000);
        check("dirty_after_commit", 32'(dirty), 32'd0);

        // Partial strobe merge
        do_write(16'h0010, 32'h1234_5678, 4'hF, 0, 0, RESP_OKAY, 1'b0);
        do_write(16'h0010, 32'hAAAA_5555, 4'h3, 0, 0, RESP_OKAY, 1'b0);
        do_read(16'h0010, 32'h1234_5555, RESP_OKAY);

        // AW leads W by three cycles, then W leads AW
        do_write(16'h0014, 32'hCAFE_F00D, 4'hF, 0, 3, RESP_OKAY, 1'b0);
        do_write(16'h0018, 32'h0BAD_BEEF, 4'hF, 3, 0, RESP_OKAY, 1'b0);
        do_read(16'h0014, 32'hCAFE_F00D, RESP_OKAY);
        do_read(16'h0018, 32'h0BAD_BEEF, RESP_OKAY);

        // Range boundary: index 40 rejected, index 39 accepted
        pulse_commit();
        do_write(16'h00A0, 32'hFFFF_FFFF, 4'hF, 0, 0, RESP_SLVERR, 1'b0);
        check("dirty_slverr", 32'(dirty), 32'd0);
        do_read(16'h00A0, 32'd0, RESP_SLVERR);
        do_read(16'h009C, 32'd0, RESP_OKAY);
        do_write(16'h009C, 32'h3939_3939, 4'hF, 0, 0, RESP_OKAY, 1'b0);
        do_read(16'h009C, 32'h3939_3939, RESP_OKAY);

        // Zero strobe is a no-op with OKAY
        do_write(16'h0008, 32'hDEAD_DEAD, 4'h0, 0, 0, RESP_OKAY, 1'b0);
        do_read(16'h0008, 32'h00FF_0000, RESP_OKAY);

        // B backpressure on an error response
        bus.axi_bready = 1'b0;
        do_write(16'h00A4, 32'h1111_1111, 4'hF, 0, 0, RESP_SLVERR, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid",  32'(bus.axi_bvalid),  32'd1);
            check("bp_bresp",   32'(bus.axi_bresp),   32'(RESP_SLVERR));
            check("bp_awready", 32'(bus.axi_awready), 32'd0);
            check("bp_wready",  32'(bus.axi_wready),  32'd0);
            tick();
        end
        bus.axi_bready = 1'b1;
        tick();
        check("bp_bvalid_clear", 32'(bus.axi_bvalid), 32'd0);

        // R backpressure
        bus.axi_rready = 1'b0;
        do_read(16'h0010, 32'h1234_5555, RESP_OKAY);
        for (int i = 0; i < 4; i++) begin
            check("rbp_rvalid",  32'(bus.axi_rvalid),  32'd1);
            check("rbp_rdata",   bus.axi_rdata,        32'h1234_5555);
            check("rbp_arready", 32'(bus.axi_arready), 32'd0);
            tick();
        end
        bus.axi_rready = 1'b1;
        tick();
        check("rbp_rvalid_clear", 32'(bus.axi_rvalid), 32'd0);

        // Write executing on the commit edge: active takes the old shadow value
        do_write(16'h0008, 32'h2222_2222, 4'hF, 0, 0, RESP_OKAY, 1'b0);
        check("active2_hold", reg_active[2], 32'h00FF_0000);
        do_write(16'h0008, 32'h3333_3333, 4'hF, 0, 0, RESP_OKAY, 1'b1);
        check("active2_same_cycle", reg_active[2], 32'h2222_2222);
        check("dirty_same_cycle", 32'(dirty), 32'd1);
        pulse_commit();
        check("active2_next_commit", reg_active[2], 32'h3333_3333);
        check("active39_commit", reg_active[39], 32'h3939_3939);
        check("dirty_next_commit", 32'(dirty), 32'd0);

        // Reset with only AW held
        bus.axi_awvalid = 1'b1;
        bus.axi_awaddr  = 16'h000C;
        @(negedge clk);
        check("aw_only_hs", 32'(bus.axi_awready), 32'd1);
        tick();
        bus.axi_awvalid = 1'b0;
        check("aw_held_awready", 32'(bus.axi_awready), 32'd0);
        reset = 1'b1;
        tick();
        check("rstmid_bvalid",  32'(bus.axi_bvalid), 32'd0);
        check("rstmid_rvalid",  32'(bus.axi_rvalid), 32'd0);
        check("rstmid_active2", reg_active[2],       32'd0);
        check("rstmid_dirty",   32'(dirty),          32'd0);
        reset = 1'b0;
        #1;
        check("rstmid_awready", 32'(bus.axi_awready), 32'd1);
        tick();
        do_read(16'h0008, 32'd0, RESP_OKAY);
        do_read(16'h000C, 32'd0, RESP_OKAY);
        do_write(16'h000C, 32'h0C0C_0C0C, 4'hF, 0, 0, RESP_OKAY, 1'b0);
        do_read(16'h000C, 32'h0C0C_0C0C, RESP_OKAY);

        repeat (2) tick();
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);
        check("r_queue_drained", 32'(exp_r.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
